// File: rtl/sys_cmd_master_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sys_cmd_master_pkg
// Purpose  : Shared definitions for the host-side command initiator: command
//            type encodings, FSM states, frame opcodes, frame lengths and the
//            helpers that pick a frame byte from (command, byte index).
// Revision : 1.0 - initial release
// ============================================================================
package sys_cmd_master_pkg;

  // Command types as presented on the request port
  typedef enum logic [1:0] {
    CMD_REG_WR  = 2'd0,
    CMD_REG_RD  = 2'd1,
    CMD_ALU_OP  = 2'd2,
    CMD_ALU_NOP = 2'd3
  } cmd_type_e;

  // Initiator FSM states
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SEND      = 3'd1,
    ST_WAIT_RSP0 = 3'd2,
    ST_WAIT_RSP1 = 3'd3,
    ST_DONE      = 3'd4
  } state_e;

  // Frame opcode bytes understood by the system controller
  localparam logic [7:0] c_op_reg_wr  = 8'hAA;
  localparam logic [7:0] c_op_reg_rd  = 8'hBB;
  localparam logic [7:0] c_op_alu_op  = 8'hCC;
  localparam logic [7:0] c_op_alu_nop = 8'hDD;

  // Index of the final byte of each frame (frame length minus one)
  localparam logic [1:0] c_last_reg_wr  = 2'd2;
  localparam logic [1:0] c_last_reg_rd  = 2'd1;
  localparam logic [1:0] c_last_alu_op  = 2'd3;
  localparam logic [1:0] c_last_alu_nop = 2'd1;

  // A captured command request; fields are frozen here at accept time
  typedef struct packed {
    cmd_type_e  ctype;
    logic [3:0] addr;
    logic [7:0] wdata;
    logic [7:0] op_a;
    logic [7:0] op_b;
    logic [3:0] func;
  } cmd_t;

  // Index of the last byte to transmit for a command type
  function automatic logic [1:0] frame_last_idx(input cmd_type_e t);
    logic [1:0] last;
    last = c_last_reg_wr;
    case (t)
      CMD_REG_WR:  last = c_last_reg_wr;
      CMD_REG_RD:  last = c_last_reg_rd;
      CMD_ALU_OP:  last = c_last_alu_op;
      CMD_ALU_NOP: last = c_last_alu_nop;
      default:     last = c_last_reg_wr;
    endcase
    return last;
  endfunction

  // ALU commands return a two-byte result, LSB first
  function automatic logic two_byte_rsp(input cmd_type_e t);
    return (t == CMD_ALU_OP) || (t == CMD_ALU_NOP);
  endfunction

  // Frame byte at position idx; 4-bit fields are zero-extended
  function automatic logic [7:0] frame_byte(input cmd_t c, input logic [1:0] idx);
    logic [7:0] b;
    b = 8'h00;
    case (c.ctype)
      CMD_REG_WR: begin
        case (idx)
          2'd0:    b = c_op_reg_wr;
          2'd1:    b = {4'h0, c.addr};
          default: b = c.wdata;
        endcase
      end
      CMD_REG_RD: begin
        case (idx)
          2'd0:    b = c_op_reg_rd;
          default: b = {4'h0, c.addr};
        endcase
      end
      CMD_ALU_OP: begin
        case (idx)
          2'd0:    b = c_op_alu_op;
          2'd1:    b = c.op_a;
          2'd2:    b = c.op_b;
          default: b = {4'h0, c.func};
        endcase
      end
      CMD_ALU_NOP: begin
        case (idx)
          2'd0:    b = c_op_alu_nop;
          default: b = {4'h0, c.func};
        endcase
      end
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sys_cmd_master_if.sv
`default_nettype none
// ============================================================================
// Module   : sys_cmd_master_if
// Purpose  : Bundles the command request, UART TX/RX byte streams and the
//            response port of the command initiator. "master" is the
//            initiator's view, "slave" is the host/UART side.
// Revision : 1.0 - initial release
// ============================================================================
interface sys_cmd_master_if;
  import sys_cmd_master_pkg::*;

  // Command request
  logic       cmd_valid;
  logic       cmd_ready;
  cmd_type_e  cmd_type;
  logic [3:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic [7:0] cmd_op_a;
  logic [7:0] cmd_op_b;
  logic [3:0] cmd_func;

  // Frame bytes toward UART TX
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  // Response bytes from UART RX
  logic [7:0] rx_data;
  logic       rx_valid;

  // Assembled result
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic        rsp_err;

  modport master (
    input  cmd_valid, cmd_type, cmd_addr, cmd_wdata, cmd_op_a, cmd_op_b, cmd_func,
    input  tx_ready, rx_data, rx_valid,
    output cmd_ready, tx_data, tx_valid, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    output cmd_valid, cmd_type, cmd_addr, cmd_wdata, cmd_op_a, cmd_op_b, cmd_func,
    output tx_ready, rx_data, rx_valid,
    input  cmd_ready, tx_data, tx_valid, rsp_valid, rsp_data, rsp_err
  );

endinterface
`default_nettype wire

// File: rtl/sys_cmd_master.sv
`default_nettype none
// ============================================================================
// Module   : sys_cmd_master
// Purpose  : Host-side initiator for the single-byte command protocol. Takes
//            one command, serialises its frame to UART TX, collects the
//            response bytes from UART RX (with a per-byte timeout) and
//            reports the assembled result for one cycle.
// Revision : 1.0 - initial release
// ============================================================================
module sys_cmd_master
  import sys_cmd_master_pkg::*;
#(
  parameter int TIMEOUT_CYC = 65535,
  parameter int TO_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  sys_cmd_master_if.master bus
);

  // Timer value at which the current wait gives up; the byte still wins on
  // that very cycle because rx_valid is tested before the timeout.
  localparam logic [TO_W-1:0] c_timer_last = TO_W'(TIMEOUT_CYC - 1);

  state_e           r_state;
  state_e           w_next_state;
  cmd_t             r_cmd;
  cmd_t             w_cmd_in;
  logic [1:0]       r_idx;
  logic [7:0]       r_tx_data;
  logic [TO_W-1:0]  r_timer;
  logic [15:0]      r_res;
  logic [15:0]      w_res_next;
  logic [15:0]      r_rsp_data;
  logic             r_rsp_err;

  logic w_accept;
  logic w_tx_fire;
  logic w_last;
  logic w_rx_take;
  logic w_timeout;
  logic w_in_wait;

  assign w_cmd_in = '{
    ctype: bus.cmd_type,
    addr:  bus.cmd_addr,
    wdata: bus.cmd_wdata,
    op_a:  bus.cmd_op_a,
    op_b:  bus.cmd_op_b,
    func:  bus.cmd_func
  };

  assign w_last    = (r_idx == frame_last_idx(r_cmd.ctype));
  assign w_in_wait = (r_state == ST_WAIT_RSP0) || (r_state == ST_WAIT_RSP1);

  // Handshake outputs decode directly from the state register, so an
  // asynchronous reset drops them at once.
  assign bus.cmd_ready = (r_state == ST_IDLE);
  assign bus.tx_valid  = (r_state == ST_SEND);
  assign bus.tx_data   = r_tx_data;
  assign bus.rsp_valid = (r_state == ST_DONE);
  assign bus.rsp_data  = r_rsp_data;
  assign bus.rsp_err   = r_rsp_err;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and per-cycle event decode
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_tx_fire    = 1'b0;
    w_rx_take    = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          w_accept     = 1'b1;
          w_next_state = ST_SEND;
        end
      end
      ST_SEND: begin
        // No timer here: a stalled UART TX simply holds the frame.
        if (bus.tx_ready) begin
          w_tx_fire = 1'b1;
          if (w_last) begin
            w_next_state = (r_cmd.ctype == CMD_REG_WR) ? ST_DONE : ST_WAIT_RSP0;
          end
        end
      end
      ST_WAIT_RSP0: begin
        if (bus.rx_valid) begin
          w_rx_take    = 1'b1;
          w_next_state = two_byte_rsp(r_cmd.ctype) ? ST_WAIT_RSP1 : ST_DONE;
        end else if (r_timer == c_timer_last) begin
          w_timeout    = 1'b1;
          w_next_state = ST_DONE;
        end
      end
      ST_WAIT_RSP1: begin
        if (bus.rx_valid) begin
          w_rx_take    = 1'b1;
          w_next_state = ST_DONE;
        end else if (r_timer == c_timer_last) begin
          w_timeout    = 1'b1;
          w_next_state = ST_DONE;
        end
      end
      ST_DONE: begin
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Merge the incoming response byte into the partial result
  always_comb begin
    w_res_next = r_res;
    if (w_rx_take) begin
      if (r_state == ST_WAIT_RSP0) begin
        w_res_next[7:0] = bus.rx_data;
      end else begin
        w_res_next[15:8] = bus.rx_data;
      end
    end
  end

  // Command capture, byte index and the registered TX byte
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cmd     <= '0;
      r_idx     <= 2'd0;
      r_tx_data <= 8'h00;
    end else if (w_accept) begin
      r_cmd     <= w_cmd_in;
      r_idx     <= 2'd0;
      r_tx_data <= frame_byte(w_cmd_in, 2'd0);
    end else if (w_tx_fire && !w_last) begin
      r_idx     <= r_idx + 2'd1;
      r_tx_data <= frame_byte(r_cmd, r_idx + 2'd1);
    end
  end

  // Per-byte response timer: restarts when a wait begins or a byte lands
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_timer <= '0;
    end else if (w_accept || w_tx_fire || w_rx_take) begin
      r_timer <= '0;
    end else if (w_in_wait && !w_timeout) begin
      r_timer <= r_timer + 1'b1;
    end
  end

  // Partial result, cleared for every new command so unused bytes read 0
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_res <= 16'h0000;
    end else if (w_accept) begin
      r_res <= 16'h0000;
    end else begin
      r_res <= w_res_next;
    end
  end

  // Reported result: loaded on entry to DONE and held until the next one
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rsp_data <= 16'h0000;
      r_rsp_err  <= 1'b0;
    end else if (w_next_state == ST_DONE) begin
      r_rsp_data <= w_res_next;
      r_rsp_err  <= w_timeout;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sys_cmd_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_sys_cmd_master
// Purpose  : Scoreboard bench for sys_cmd_master. Stimulus pushes the frame
//            bytes and results it expects; a negedge monitor pops and
//            compares every TX handshake and every response pulse.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sys_cmd_master;
  import sys_cmd_master_pkg::*;

  typedef struct {
    logic [15:0] data;
    logic [15:0] mask;
    logic        err;
  } rsp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] exp_tx[$];
  rsp_t       exp_rsp[$];

  int tx_mode      = 0;   // 0: ready high, 1: random, 2: held low
  int accept_cyc   = 0;
  int rx_cyc       = 0;
  int last_rsp_cyc = 0;

  sys_cmd_master_if bus();

  sys_cmd_master #(
    .TIMEOUT_CYC (20),
    .TO_W        (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic expect_rsp(input logic [15:0] d, input logic [15:0] m, input logic e);
    rsp_t r;
    r.data = d;
    r.mask = m;
    r.err  = e;
    exp_rsp.push_back(r);
  endtask

  // Present a command, wait for acceptance, then scramble the fields
  task automatic issue(input cmd_type_e t, input logic [3:0] addr, input logic [7:0] wdata,
                       input logic [7:0] a, input logic [7:0] b, input logic [3:0] func);
    bit ok;
    ok = 1'b0;
    @(posedge clk); #1;
    bus.cmd_type  = t;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = wdata;
    bus.cmd_op_a  = a;
    bus.cmd_op_b  = b;
    bus.cmd_func  = func;
    bus.cmd_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.cmd_ready) begin
        ok = 1'b1;
        break;
      end
    end
    accept_cyc = cyc;
    if (!ok) fail_now("cmd_accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_type  = cmd_type_e'(~t);
    bus.cmd_addr  = ~addr;
    bus.cmd_wdata = ~wdata;
    bus.cmd_op_a  = ~a;
    bus.cmd_op_b  = ~b;
    bus.cmd_func  = ~func;
  endtask

  // Call at a posedge: one-cycle rx strobe sampled on the following edge
  task automatic pulse_rx(input logic [7:0] d);
    #1;
    bus.rx_valid = 1'b1;
    bus.rx_data  = d;
    rx_cyc       = cyc;
    @(posedge clk); #1;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
  endtask

  // Returns on the edge that completes the last expected TX handshake
  task automatic wait_tx_empty();
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      if (exp_tx.size() == 0) break;
    end
    if (exp_tx.size() != 0) fail_now("tx_wait_timeout", exp_tx.size(), 32'd0);
  endtask

  task automatic wait_rsp();
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      if (exp_rsp.size() == 0) break;
    end
    if (exp_rsp.size() != 0) fail_now("rsp_wait_timeout", exp_rsp.size(), 32'd0);
  endtask

  // tx_ready driver
  initial begin
    bus.tx_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (tx_mode)
        1:       bus.tx_ready = 1'($urandom_range(0, 1));
        2:       bus.tx_ready = 1'b0;
        default: bus.tx_ready = 1'b1;
      endcase
    end
  end

  // Monitor: TX byte order/stability and response contents
  initial begin
    logic       hold_pending;
    logic [7:0] hold_data;
    rsp_t       e;
    hold_pending = 1'b0;
    hold_data    = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst) begin
        hold_pending = 1'b0;
      end else begin
        if (bus.tx_valid) begin
          if (hold_pending) check("tx_hold_stable", bus.tx_data, hold_data);
          if (bus.tx_ready) begin
            hold_pending = 1'b0;
            if (exp_tx.size() == 0) fail_now("tx_unexpected_byte", bus.tx_data, 32'd0);
            else check("tx_byte", bus.tx_data, exp_tx.pop_front());
          end else begin
            hold_pending = 1'b1;
            hold_data    = bus.tx_data;
          end
        end else begin
          hold_pending = 1'b0;
        end
        if (bus.rsp_valid) begin
          last_rsp_cyc = cyc;
          if (exp_rsp.size() == 0) begin
            fail_now("rsp_unexpected", bus.rsp_data, 32'd0);
          end else begin
            e = exp_rsp.pop_front();
            check("rsp_data", bus.rsp_data & e.mask, e.data & e.mask);
            check("rsp_err", bus.rsp_err, e.err);
          end
        end
      end
    end
  end

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // Stimulus
  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_type  = CMD_REG_WR;
    bus.cmd_addr  = 4'h0;
    bus.cmd_wdata = 8'h00;
    bus.cmd_op_a  = 8'h00;
    bus.cmd_op_b  = 8'h00;
    bus.cmd_func  = 4'h0;
    bus.rx_valid  = 1'b0;
    bus.rx_data   = 8'h00;

    repeat (3) @(posedge clk);
    #1;
    check("rst_cmd_ready", bus.cmd_ready, 32'd1);
    check("rst_tx_valid",  bus.tx_valid,  32'd0);
    check("rst_tx_data",   bus.tx_data,   32'd0);
    check("rst_rsp_valid", bus.rsp_valid, 32'd0);
    check("rst_rsp_data",  bus.rsp_data,  32'd0);
    check("rst_rsp_err",   bus.rsp_err,   32'd0);
    #2 rst = 1'b1;

    // rx strobe while idle must not produce anything
    @(posedge clk);
    pulse_rx(8'h99);
    repeat (3) @(posedge clk);

    // REG_WR: three bytes, no response bytes, minimum latency
    exp_tx.push_back(8'hAA); exp_tx.push_back(8'h05); exp_tx.push_back(8'h3C);
    expect_rsp(16'h0000, 16'hFFFF, 1'b0);
    issue(CMD_REG_WR, 4'h5, 8'h3C, 8'h00, 8'h00, 4'h0);
    wait_rsp();
    // accept cycle counted as 1, rsp_valid in cycle 5
    check("wr_latency", last_rsp_cyc - accept_cyc, 32'd4);

    // REG_RD: response 10 cycles after the last TX byte
    exp_tx.push_back(8'hBB); exp_tx.push_back(8'h02);
    expect_rsp(16'h007E, 16'hFFFF, 1'b0);
    issue(CMD_REG_RD, 4'h2, 8'h00, 8'h00, 8'h00, 4'h0);
    wait_tx_empty();
    repeat (9) @(posedge clk);
    pulse_rx(8'h7E);
    wait_rsp();

    // tx_ready held low well past the timeout: frame waits, no error
    tx_mode = 2;
    @(posedge clk);
    exp_tx.push_back(8'hBB); exp_tx.push_back(8'h09);
    expect_rsp(16'h006D, 16'hFFFF, 1'b0);
    issue(CMD_REG_RD, 4'h9, 8'h00, 8'h00, 8'h00, 4'h0);
    repeat (40) @(negedge clk);
    check("stall_tx_valid", bus.tx_valid, 32'd1);
    check("stall_tx_data",  bus.tx_data,  32'hBB);
    check("stall_rsp_pending", exp_rsp.size(), 32'd1);
    tx_mode = 0;
    wait_tx_empty();
    repeat (2) @(posedge clk);
    pulse_rx(8'h6D);
    wait_rsp();

    // Byte arriving on the cycle the timer expires wins
    exp_tx.push_back(8'hBB); exp_tx.push_back(8'h0F);
    expect_rsp(16'h00C5, 16'hFFFF, 1'b0);
    issue(CMD_REG_RD, 4'hF, 8'h00, 8'h00, 8'h00, 4'h0);
    wait_tx_empty();
    repeat (19) @(posedge clk);
    pulse_rx(8'hC5);
    wait_rsp();

    // ALU_OP: two response bytes, LSB first
    exp_tx.push_back(8'hCC); exp_tx.push_back(8'h12);
    exp_tx.push_back(8'h34); exp_tx.push_back(8'h02);
    expect_rsp(16'h03A8, 16'hFFFF, 1'b0);
    issue(CMD_ALU_OP, 4'h0, 8'h00, 8'h12, 8'h34, 4'h2);
    wait_tx_empty();
    pulse_rx(8'hA8);
    repeat (3) @(posedge clk);
    pulse_rx(8'h03);
    wait_rsp();
    repeat (3) @(negedge clk);
    check("hold_rsp_data",  bus.rsp_data,  32'h03A8);
    check("hold_rsp_err",   bus.rsp_err,   32'd0);
    check("hold_rsp_valid", bus.rsp_valid, 32'd0);

    // ALU_NOP: one byte then silence -> timeout, LSB kept
    exp_tx.push_back(8'hDD); exp_tx.push_back(8'h01);
    expect_rsp(16'h0055, 16'h00FF, 1'b1);
    issue(CMD_ALU_NOP, 4'h0, 8'h00, 8'h00, 8'h00, 4'h1);
    wait_tx_empty();
    pulse_rx(8'h55);
    wait_rsp();
    // byte sampled on the edge after it is driven, then 20 edges to DONE
    check("timeout_latency", last_rsp_cyc - rx_cyc, 32'd21);
    repeat (3) @(negedge clk);
    check("hold_err", bus.rsp_err, 32'd1);

    // ALU_OP with random tx_ready, stray rx and a rejected request mid-frame
    tx_mode = 1;
    exp_tx.push_back(8'hCC); exp_tx.push_back(8'h5A);
    exp_tx.push_back(8'hC3); exp_tx.push_back(8'h0F);
    expect_rsp(16'h2211, 16'hFFFF, 1'b0);
    issue(CMD_ALU_OP, 4'h0, 8'h00, 8'h5A, 8'hC3, 4'hF);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b1;
    bus.rx_valid  = 1'b1;
    bus.rx_data   = 8'hEE;
    @(posedge clk); #1;
    bus.rx_valid  = 1'b0;
    bus.rx_data   = 8'h00;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    wait_tx_empty();
    tx_mode = 0;
    pulse_rx(8'h11);
    @(posedge clk);
    pulse_rx(8'h22);
    wait_rsp();

    // Asynchronous reset after the 2nd byte of an ALU_OP frame
    exp_tx.push_back(8'hCC); exp_tx.push_back(8'h12);
    exp_tx.push_back(8'h34); exp_tx.push_back(8'h02);
    issue(CMD_ALU_OP, 4'h0, 8'h00, 8'h12, 8'h34, 4'h2);
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("abort_tx_left",  exp_tx.size(), 32'd2);
    check("arst_cmd_ready", bus.cmd_ready, 32'd1);
    check("arst_tx_valid",  bus.tx_valid,  32'd0);
    check("arst_tx_data",   bus.tx_data,   32'd0);
    check("arst_rsp_valid", bus.rsp_valid, 32'd0);
    check("arst_rsp_data",  bus.rsp_data,  32'd0);
    check("arst_rsp_err",   bus.rsp_err,   32'd0);
    exp_tx.delete();
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;

    // A fresh REG_WR completes normally after the abort
    exp_tx.push_back(8'hAA); exp_tx.push_back(8'h0A); exp_tx.push_back(8'h5F);
    expect_rsp(16'h0000, 16'hFFFF, 1'b0);
    issue(CMD_REG_WR, 4'hA, 8'h5F, 8'h00, 8'h00, 4'h0);
    wait_rsp();

    repeat (5) @(posedge clk);
    check("end_tx_queue",  exp_tx.size(),  32'd0);
    check("end_rsp_queue", exp_rsp.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
